// File: rtl/video_pattern_gen.sv
// video_pattern_gen: AXI4-Stream 24-bit test-pattern source (bars, ramp, checkerboard, solid)
module video_pattern_gen #(
  parameter int H_ACTIVE   = 1280,
  parameter int V_ACTIVE   = 720,
  parameter int GAP_CYCLES = 0
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [23:0] solid_rgb,
  output logic [23:0] m_axis_video_tdata,
  output logic        m_axis_video_tvalid,
  input  logic        m_axis_video_tready,
  output logic        m_axis_video_tuser,
  output logic        m_axis_video_tlast,
  output logic        frame_done,
  output logic [15:0] frame_count
);
  typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;
  localparam int BW = H_ACTIVE / 8;
  localparam logic [11:0] X_LAST = 12'(H_ACTIVE - 1);
  localparam logic [11:0] Y_LAST = 12'(V_ACTIVE - 1);
  localparam logic [11:0] B_LAST = 12'(BW - 1);
  localparam logic [15:0] G_LAST = 16'(GAP_CYCLES - 1);
  localparam logic HAS_GAP = GAP_CYCLES > 0;
  state_t state, state_nx;
  // x/y/bar/bcnt address the next pixel to load into the output register
  logic [11:0] x, y, bcnt, sx, sy, sbc;
  logic [2:0]  bar, sbar;
  logic [1:0]  pat, spat;
  logic [23:0] rgb, srgb, px;
  logic [15:0] gcnt;
  logic        eof, hs, fin, gap_done, restart, ld, xl, yl, bl;
  assign hs       = m_axis_video_tvalid & m_axis_video_tready;
  assign fin      = (state == ACTIVE) & hs & eof;
  assign gap_done = (state == GAP) & (gcnt == G_LAST);
  assign restart  = ((fin & ~HAS_GAP) | gap_done) & enable;
  assign ld       = restart | ((state == ACTIVE) & (~m_axis_video_tvalid | (m_axis_video_tready & ~eof)));
  // state register
  always_ff @(posedge aclk)
    if (!aresetn) state <= IDLE;
    else state <= state_nx;
  // next state: frames always run to completion before enable is reconsidered
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE) ? (enable ? ACTIVE : IDLE) :
               (fin && HAS_GAP) ? GAP :
               (fin || gap_done) ? (enable ? ACTIVE : IDLE) : state;
  end
  // pixel source: a frame restart loads (0,0) straight from the live inputs so no bubble appears
  always_comb begin
    sx   = restart ? '0 : x;
    sy   = restart ? '0 : y;
    sbc  = restart ? '0 : bcnt;
    sbar = restart ? '0 : bar;
    spat = restart ? pattern_sel : pat;
    srgb = restart ? solid_rgb : rgb;
    xl   = sx == X_LAST;
    yl   = sy == Y_LAST;
    bl   = sbc == B_LAST;
    px   = (spat == 2'd0) ? {{8{~sbar[1]}}, {8{~sbar[0]}}, {8{~sbar[2]}}} :
           (spat == 2'd1) ? {3{sx[7:0]}} :
           (spat == 2'd2) ? {24{~(sx[3] ^ sy[3])}} : srgb;
  end
  // output register, position counters, frame accounting and gap timer
  always_ff @(posedge aclk)
    if (!aresetn) begin
      m_axis_video_tdata  <= '0;
      m_axis_video_tvalid <= 1'b0;
      m_axis_video_tuser  <= 1'b0;
      m_axis_video_tlast  <= 1'b0;
      frame_done          <= 1'b0;
      frame_count         <= '0;
      x    <= '0;
      y    <= '0;
      bcnt <= '0;
      bar  <= '0;
      pat  <= '0;
      rgb  <= '0;
      eof  <= 1'b0;
      gcnt <= '0;
    end else begin
      frame_done <= fin;
      if (fin) frame_count <= frame_count + 16'd1;
      if ((state == IDLE && enable) || restart) begin
        pat <= pattern_sel;
        rgb <= solid_rgb;
      end
      if (ld) begin
        m_axis_video_tdata  <= px;
        m_axis_video_tvalid <= 1'b1;
        m_axis_video_tuser  <= (sx == '0) && (sy == '0);
        m_axis_video_tlast  <= xl;
        eof  <= xl & yl;
        x    <= xl ? '0 : sx + 12'd1;
        y    <= xl ? (yl ? '0 : sy + 12'd1) : sy;
        bcnt <= (xl | bl) ? '0 : sbc + 12'd1;
        bar  <= xl ? '0 : (bl && sbar != 3'd7) ? sbar + 3'd1 : sbar;
      end else if (fin) begin
        m_axis_video_tvalid <= 1'b0;
      end
      if (state == IDLE) begin
        x    <= '0;
        y    <= '0;
        bcnt <= '0;
        bar  <= '0;
      end
      gcnt <= (state == GAP) ? gcnt + 16'd1 : '0;
    end
endmodule

// File: tb/tb_video_pattern_gen.sv
// tb_video_pattern_gen: randomized self-checking bench for video_pattern_gen against a pixel-rule model
module tb_video_pattern_gen;
  localparam int HS [3] = '{16, 20, 300};
  localparam int VS [3] = '{4, 2, 1};
  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFF00FF, 24'h00FFFF, 24'h0000FF,
                                      24'hFFFF00, 24'hFF0000, 24'h00FF00, 24'h000000};
  logic        aclk = 0, aresetn = 0, enable = 0, tready = 1;
  logic [1:0]  pattern_sel = 0;
  logic [23:0] solid_rgb = 0;
  logic [23:0] tdata [3];
  logic        tvalid [3], tuser [3], tlast [3], fdone [3];
  logic [15:0] fcount [3];
  int nchk = 0, nerr = 0, stall_err = 0;
  logic [23:0] cap_d [$];
  logic        cap_u [$], cap_l [$];
  int          fpat [$];
  logic [23:0] frgb [$];

  always #5 aclk = ~aclk;

  video_pattern_gen #(.H_ACTIVE(16), .V_ACTIVE(4), .GAP_CYCLES(0)) u0 (
    .aclk(aclk), .aresetn(aresetn), .enable(enable), .pattern_sel(pattern_sel), .solid_rgb(solid_rgb),
    .m_axis_video_tdata(tdata[0]), .m_axis_video_tvalid(tvalid[0]), .m_axis_video_tready(tready),
    .m_axis_video_tuser(tuser[0]), .m_axis_video_tlast(tlast[0]), .frame_done(fdone[0]), .frame_count(fcount[0]));
  video_pattern_gen #(.H_ACTIVE(20), .V_ACTIVE(2), .GAP_CYCLES(0)) u1 (
    .aclk(aclk), .aresetn(aresetn), .enable(enable), .pattern_sel(pattern_sel), .solid_rgb(solid_rgb),
    .m_axis_video_tdata(tdata[1]), .m_axis_video_tvalid(tvalid[1]), .m_axis_video_tready(tready),
    .m_axis_video_tuser(tuser[1]), .m_axis_video_tlast(tlast[1]), .frame_done(fdone[1]), .frame_count(fcount[1]));
  video_pattern_gen #(.H_ACTIVE(300), .V_ACTIVE(1), .GAP_CYCLES(5)) u2 (
    .aclk(aclk), .aresetn(aresetn), .enable(enable), .pattern_sel(pattern_sel), .solid_rgb(solid_rgb),
    .m_axis_video_tdata(tdata[2]), .m_axis_video_tvalid(tvalid[2]), .m_axis_video_tready(tready),
    .m_axis_video_tuser(tuser[2]), .m_axis_video_tlast(tlast[2]), .frame_done(fdone[2]), .frame_count(fcount[2]));

  function automatic logic [23:0] model_px(input int pat, input logic [23:0] rgb, input int x, input int y, input int h);
    int b;
    b = x / (h / 8);
    if (b > 7) b = 7;
    case (pat)
      0: return BARS[b];
      1: return {3{8'(x % 256)}};
      2: return (((x / 8) % 2) != ((y / 8) % 2)) ? 24'h000000 : 24'hFFFFFF;
      default: return rgb;
    endcase
  endfunction

  task automatic reset_dut();
    aresetn = 0; enable = 0; tready = 1; pattern_sel = 0; solid_rgb = 0;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1;
    cap_d.delete(); cap_u.delete(); cap_l.delete(); fpat.delete(); frgb.delete();
    stall_err = 0;
  endtask

  task automatic start_frame(input logic [1:0] p, input logic [23:0] c);
    pattern_sel = p; solid_rgb = c; enable = 1;
    fpat.push_back(int'(p)); frgb.push_back(c);
    @(posedge aclk); #1;
  endtask

  // collects n accepted beats of instance k; tracks stall stability and what each next frame latches
  task automatic capture(input int k, input int n, input bit rr, input bit rp, output int cyc);
    int got = 0, fs = HS[k] * VS[k];
    bit held = 0;
    logic [23:0] hd = 0;
    logic hu = 0, hl = 0;
    cyc = 0;
    while (got < n && cyc < 20000) begin
      @(posedge aclk); #1; cyc++;
      if (held && (tvalid[k] !== 1'b1 || tdata[k] !== hd || tuser[k] !== hu || tlast[k] !== hl)) stall_err++;
      if (rp && $urandom_range(0, 3) == 0) begin
        pattern_sel = 2'($urandom_range(0, 3));
        solid_rgb = 24'($urandom);
      end
      tready = rr ? 1'($urandom_range(0, 1)) : 1'b1;
      held = tvalid[k] && !tready;
      hd = tdata[k]; hu = tuser[k]; hl = tlast[k];
      if (tvalid[k] && tready) begin
        cap_d.push_back(tdata[k]); cap_u.push_back(tuser[k]); cap_l.push_back(tlast[k]);
        got++;
        if (cap_d.size() % fs == 0) begin
          fpat.push_back(int'(pattern_sel)); frgb.push_back(solid_rgb);
        end
      end
    end
    nchk++;
    if (got != n) begin nerr++; $display("FAIL capture_timeout inst %0d got %0d beats required %0d", k, got, n); end
  endtask

  task automatic test_reset();
    reset_dut();
    enable = 1; pattern_sel = 3; solid_rgb = 24'h123456;
    repeat (5) @(posedge aclk);
    #1 aresetn = 0;
    @(posedge aclk); #1;
    for (int k = 0; k < 3; k++) begin
      nchk++; if (tvalid[k] !== 1'b0) begin nerr++; $display("FAIL reset_tvalid inst %0d got %b required 0", k, tvalid[k]); end
      nchk++; if (tdata[k] !== 24'h0) begin nerr++; $display("FAIL reset_tdata inst %0d got %h required 0", k, tdata[k]); end
      nchk++; if (tuser[k] !== 1'b0) begin nerr++; $display("FAIL reset_tuser inst %0d got %b required 0", k, tuser[k]); end
      nchk++; if (tlast[k] !== 1'b0) begin nerr++; $display("FAIL reset_tlast inst %0d got %b required 0", k, tlast[k]); end
      nchk++; if (fdone[k] !== 1'b0) begin nerr++; $display("FAIL reset_frame_done inst %0d got %b required 0", k, fdone[k]); end
      nchk++; if (fcount[k] !== 16'h0) begin nerr++; $display("FAIL reset_frame_count inst %0d got %0d required 0", k, fcount[k]); end
    end
    reset_dut();
    repeat (3) @(posedge aclk);
    #1;
    nchk++; if (tvalid[0] !== 1'b0) begin nerr++; $display("FAIL idle_tvalid got %b required 0", tvalid[0]); end
  endtask

  task automatic test_bars();
    int cyc;
    reset_dut();
    start_frame(2'd0, 24'h0);
    nchk++; if (tvalid[0] !== 1'b0) begin nerr++; $display("FAIL start_latency tvalid got %b required 0", tvalid[0]); end
    capture(0, 64, 0, 0, cyc);
    enable = 0;
    nchk++; if (cyc != 64) begin nerr++; $display("FAIL bars_cycles got %0d required 64", cyc); end
    for (int i = 0; i < cap_d.size(); i++) begin
      int p = i % 64;
      logic [23:0] e = model_px(fpat[i / 64], frgb[i / 64], p % 16, p / 16, 16);
      nchk++;
      if (cap_d[i] !== e || cap_u[i] !== (p == 0) || cap_l[i] !== (p % 16 == 15)) begin
        nerr++; $display("FAIL bars_beat %0d got %h/%b/%b required %h/%b/%b", i, cap_d[i], cap_u[i], cap_l[i], e, p == 0, p % 16 == 15);
      end
    end
    @(posedge aclk); #1;
    nchk++; if (fdone[0] !== 1'b1) begin nerr++; $display("FAIL bars_frame_done got %b required 1", fdone[0]); end
    nchk++; if (fcount[0] !== 16'd1) begin nerr++; $display("FAIL bars_frame_count got %0d required 1", fcount[0]); end
    @(posedge aclk); #1;
    nchk++; if (fdone[0] !== 1'b0) begin nerr++; $display("FAIL bars_done_pulse got %b required 0", fdone[0]); end
    nchk++; if (tvalid[0] !== 1'b0) begin nerr++; $display("FAIL bars_idle_tvalid got %b required 0", tvalid[0]); end
  endtask

  task automatic test_bar_remainder();
    int cyc, nb = 0;
    reset_dut();
    start_frame(2'd0, 24'h0);
    capture(1, 40, 0, 0, cyc);
    enable = 0;
    for (int i = 0; i < cap_d.size(); i++) begin
      int p = i % 40;
      logic [23:0] e = model_px(fpat[0], frgb[0], p % 20, p / 20, 20);
      nchk++;
      if (cap_d[i] !== e || cap_u[i] !== (p == 0) || cap_l[i] !== (p % 20 == 19)) begin
        nerr++; $display("FAIL rem_beat %0d got %h/%b/%b required %h", i, cap_d[i], cap_u[i], cap_l[i], e);
      end
    end
    for (int i = 0; i < 20 && i < cap_d.size(); i++) if (cap_d[i] === 24'h0) nb++;
    nchk++; if (nb != 6) begin nerr++; $display("FAIL rem_black_width got %0d required 6", nb); end
    nchk++; if (cap_d.size() > 13 && cap_d[13] !== 24'h00FF00) begin nerr++; $display("FAIL rem_blue_px13 got %h required 00ff00", cap_d[13]); end
  endtask

  task automatic test_ramp();
    int cyc;
    reset_dut();
    start_frame(2'd1, 24'h0);
    capture(2, 300, 0, 0, cyc);
    enable = 0;
    for (int i = 0; i < cap_d.size(); i++) begin
      logic [23:0] e = model_px(fpat[0], frgb[0], i, 0, 300);
      nchk++;
      if (cap_d[i] !== e || cap_u[i] !== (i == 0) || cap_l[i] !== (i == 299)) begin
        nerr++; $display("FAIL ramp_beat %0d got %h/%b/%b required %h/%b/%b", i, cap_d[i], cap_u[i], cap_l[i], e, i == 0, i == 299);
      end
    end
    if (cap_d.size() == 300) begin
      nchk++; if (cap_d[255] !== 24'hFFFFFF) begin nerr++; $display("FAIL ramp_px255 got %h required ffffff", cap_d[255]); end
      nchk++; if (cap_d[256] !== 24'h000000) begin nerr++; $display("FAIL ramp_px256 got %h required 000000", cap_d[256]); end
      nchk++; if (cap_d[299] !== 24'h2B2B2B) begin nerr++; $display("FAIL ramp_px299 got %h required 2b2b2b", cap_d[299]); end
    end
  endtask

  task automatic test_random_backpressure();
    int cyc;
    reset_dut();
    start_frame(2'($urandom_range(0, 3)), 24'($urandom));
    capture(0, 192, 1, 1, cyc);
    enable = 0;
    for (int i = 0; i < cap_d.size(); i++) begin
      int p = i % 64;
      logic [23:0] e = model_px(fpat[i / 64], frgb[i / 64], p % 16, p / 16, 16);
      nchk++;
      if (cap_d[i] !== e || cap_u[i] !== (p == 0) || cap_l[i] !== (p % 16 == 15)) begin
        nerr++; $display("FAIL rand_beat %0d frame %0d pat %0d got %h/%b/%b required %h", i, i / 64, fpat[i / 64], cap_d[i], cap_u[i], cap_l[i], e);
      end
    end
    nchk++; if (stall_err != 0) begin nerr++; $display("FAIL rand_stall_stability got %0d violations required 0", stall_err); end
    tready = 1;
    @(posedge aclk); #1;
    nchk++; if (fcount[0] !== 16'd3) begin nerr++; $display("FAIL rand_frame_count got %0d required 3", fcount[0]); end
  endtask

  task automatic test_enable_drop();
    int cyc;
    logic [23:0] c = 24'($urandom);
    reset_dut();
    start_frame(2'd2, c);
    capture(0, 10, 0, 0, cyc);
    enable = 0; pattern_sel = 3;
    capture(0, 54, 0, 0, cyc);
    for (int i = 0; i < cap_d.size(); i++) begin
      logic [23:0] e = model_px(2, c, i % 16, i / 16, 16);
      nchk++;
      if (cap_d[i] !== e) begin nerr++; $display("FAIL drop_beat %0d got %h required %h", i, cap_d[i], e); end
    end
    @(posedge aclk);
    for (int j = 0; j < 4; j++) begin
      @(posedge aclk); #1;
      nchk++; if (tvalid[0] !== 1'b0) begin nerr++; $display("FAIL drop_idle cycle %0d tvalid got %b required 0", j, tvalid[0]); end
    end
    reset_dut();
    start_frame(2'd2, c);
    capture(0, 10, 0, 0, cyc);
    pattern_sel = 3;
    capture(0, 118, 0, 0, cyc);
    enable = 0;
    for (int i = 0; i < cap_d.size(); i++) begin
      int p = i % 64;
      logic [23:0] e = model_px(fpat[i / 64], frgb[i / 64], p % 16, p / 16, 16);
      nchk++;
      if (cap_d[i] !== e) begin nerr++; $display("FAIL held_beat %0d got %h required %h", i, cap_d[i], e); end
    end
    nchk++; if (cap_d.size() > 64 && cap_d[64] !== c) begin nerr++; $display("FAIL held_solid got %h required %h", cap_d[64], c); end
  endtask

  task automatic test_gap_reset();
    int cyc, low = 0;
    bit seen = 0;
    logic [23:0] c = 24'($urandom);
    reset_dut();
    start_frame(2'd3, c);
    capture(2, 300, 0, 0, cyc);
    for (int j = 0; j < 50 && !seen; j++) begin
      @(posedge aclk); #1;
      if (tvalid[2]) seen = 1; else low++;
    end
    nchk++; if (!seen || low != 5) begin nerr++; $display("FAIL gap_cycles got %0d (seen %b) required 5", low, seen); end
    nchk++; if (tuser[2] !== 1'b1 || tdata[2] !== c) begin nerr++; $display("FAIL gap_restart got %h/%b required %h/1", tdata[2], tuser[2], c); end
    nchk++; if (fcount[2] !== 16'd1) begin nerr++; $display("FAIL gap_frame_count got %0d required 1", fcount[2]); end
    repeat (20) @(posedge aclk);
    #1 aresetn = 0;
    @(posedge aclk); #1;
    nchk++;
    if (tvalid[2] !== 0 || tdata[2] !== 0 || tuser[2] !== 0 || tlast[2] !== 0 || fdone[2] !== 0 || fcount[2] !== 0) begin
      nerr++; $display("FAIL midframe_reset got v%b d%h u%b l%b fd%b fc%0d required all 0", tvalid[2], tdata[2], tuser[2], tlast[2], fdone[2], fcount[2]);
    end
    aresetn = 1;
    @(posedge aclk); #1;
    nchk++; if (tvalid[2] !== 1'b0) begin nerr++; $display("FAIL post_reset_latency tvalid got %b required 0", tvalid[2]); end
    @(posedge aclk); #1;
    nchk++;
    if (tvalid[2] !== 1'b1 || tuser[2] !== 1'b1 || tdata[2] !== c || fcount[2] !== 16'd0) begin
      nerr++; $display("FAIL post_reset_restart got v%b u%b d%h fc%0d required 1/1/%h/0", tvalid[2], tuser[2], tdata[2], fcount[2], c);
    end
    enable = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_bars();
    test_bar_remainder();
    test_ramp();
    test_random_backpressure();
    test_enable_drop();
    test_gap_reset();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/video_pattern_gen.md
# video_pattern_gen

AXI4-Stream video source that produces 24-bit test-pattern frames for the video pipeline. It drives the same stream interface the greyscale filter consumes, and substitutes for the `v_vid_in_axi4s` input bridge during bring-up and in simulation. It generates colour bars, a ramp, a checkerboard or a solid colour. It marks start-of-frame on `tuser` and end-of-line on `tlast`, and fully honours downstream back-pressure.

## Interface

Parameters:
- H_ACTIVE, default 1280: pixels per line; legal range 8..4096.
- V_ACTIVE, default 720: lines per frame; legal range 1..4096.
- GAP_CYCLES, default 0: idle cycles, with `tvalid` low, inserted between consecutive frames; legal range 0..65535.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset, synchronous, active-low (clock aclk).
- enable  in  1  run request; sampled only at frame boundaries.
- pattern_sel  in  2  0 = colour bars, 1 = horizontal ramp, 2 = checkerboard, 3 = solid colour.
- solid_rgb  in  24  colour used for pattern 3, in the same packing as tdata.
- m_axis_video_tdata  out  24  pixel packed as {R[23:16], B[15:8], G[7:0]}.
- m_axis_video_tvalid  out  1  pixel valid.
- m_axis_video_tready  in  1  downstream ready.
- m_axis_video_tuser  out  1  start of frame; high on pixel (0,0) only.
- m_axis_video_tlast  out  1  end of line; high on x = H_ACTIVE-1.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.
- frame_count  out  16  count of completed frames; wraps from 0xFFFF to 0.

## Operation

- States: IDLE, ACTIVE, GAP.
- IDLE: `tvalid` is 0. When `enable` = 1, latch `pattern_sel` and `solid_rgb`, set x = 0 and y = 0, and go to ACTIVE.
- ACTIVE: present pixel (x,y). On handshake (`tvalid` && `tready`), advance x. On x = H_ACTIVE-1, wrap x to 0 and increment y. On the handshake of the last pixel (x = H_ACTIVE-1, y = V_ACTIVE-1):
  - pulse `frame_done` and increment `frame_count`;
  - if GAP_CYCLES > 0, go to GAP;
  - otherwise, if `enable` = 1, re-latch the inputs and start the next frame with no bubble;
  - otherwise go to IDLE.
- GAP: count GAP_CYCLES cycles with `tvalid` low. Then go to ACTIVE if `enable` = 1 (re-latching the inputs), else to IDLE.
- Deasserting `enable` mid-frame has no effect until the current frame completes; frames are never truncated.
- Changes to `pattern_sel` or `solid_rgb` mid-frame are ignored until the next frame start.
- Pattern 0, colour bars:
  - Bar width BW = H_ACTIVE/8 (floor). A bar counter advances every BW pixels and saturates at 7, so bar 7 absorbs the remainder.
  - Colour order: white, yellow, cyan, green, magenta, red, blue, black.
  - Each channel is 0xFF or 0x00.
- Pattern 1, ramp: R = G = B = x[7:0], wrapping every 256 pixels.
- Pattern 2, checkerboard: 8x8 cells. Pixel is 0xFFFFFF if x[3] XOR y[3] = 0, else 0x000000.
- Pattern 3: every pixel equals the latched `solid_rgb`.
- Pixel values are computed from counters only; no dividers or multipliers in the datapath.

## Timing

- Reset values: `tvalid` = 0, `tdata` = 0, `tuser` = 0, `tlast` = 0, `frame_done` = 0, `frame_count` = 0, state = IDLE, x = 0, y = 0.
- All outputs are registered.
- `enable` seen high in IDLE at edge N gives `tvalid` = 1 with pixel (0,0) and `tuser` = 1 after edge N+1.
- With `tready` held high: one pixel per clock; a frame occupies exactly H_ACTIVE×V_ACTIVE + GAP_CYCLES cycles.
- Once `tvalid` is high, `tdata`, `tuser` and `tlast` hold stable until accepted. `tvalid` never drops without a handshake.
- `tready` low stalls all counters. `tready` may toggle every cycle without loss or duplication of pixels.
- `frame_done` is high for exactly the cycle after the final handshake. `frame_count` updates on the same edge.
- Reset asserted mid-frame: on the next edge all outputs return to reset values; no partial-frame completion.
- V_ACTIVE = 1: every pixel has y = 0. `tuser` and `tlast` occur in the same frame; `tlast` only on the final pixel.

## Test plan

- H_ACTIVE=16, V_ACTIVE=4, pattern 0, `tready` = 1 -> 64 pixels; `tdata` sequence is pairs 0xFFFFFF, 0xFF00FF, 0x00FFFF, 0x0000FF, 0xFFFF00, 0xFF0000, 0x00FF00, 0x000000 per line; `tuser` only on beat 0; `tlast` on beats 15, 31, 47, 63; `frame_done` pulse; `frame_count` = 1.
- H_ACTIVE=20, pattern 0 -> bars 0..6 are 2 pixels wide and bar 7 (black) is 6 pixels.
- Pattern 1, H_ACTIVE=300 -> pixel 255 = 0xFFFFFF, pixel 256 = 0x000000, pixel 299 = 0x2B2B2B.
- Random `tready` (50%) over 3 frames, compared against a reference model -> identical pixel stream; `tdata`/`tuser`/`tlast` stable during every stall.
- Drop `enable` at pixel 10 of frame 0; change `pattern_sel` from 2 to 3 mid-frame -> frame 0 completes entirely as checkerboard, then IDLE with `tvalid` = 0. With `enable` held instead, frame 1 is solid `solid_rgb`.
- GAP_CYCLES=5, then reset asserted mid-frame -> exactly 5 `tvalid`-low cycles between frames; after reset, all outputs 0 and the next frame restarts at (0,0) with `tuser` = 1.
